rr_port_arbiter: RTL and testbench

Rotating-priority output-port arbiter for the router's port-allocation path. It takes a per-cycle 5-port request vector and rotates it so the current priority port sits at the top bit. A fixed highest-bit picker then selects one port, and the arbiter registers a one-hot grant with a valid/ready handshake. Grants can be held across multi-flit packets via `lock`, and priority advances round-robin after each released grant.

---
 rtl/rr_port_arbiter_pkg.sv | 50 +++++
 rtl/rr_port_arbiter_prio_pick5.sv | 21 ++
 rtl/rr_port_arbiter.sv | 99 +++++++++
 tb/tb_rr_port_arbiter.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/rr_port_arbiter_pkg.sv
// rr_port_arbiter_pkg
//   Shared constants, FSM state encoding and pointer/rotation helpers for the
//   rotating-priority output-port arbiter. The rotation helpers are written
//   for exactly five ports.
package rr_port_arbiter_pkg;

  localparam int NUM_PORT = 5;
  localparam int PTR_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_LOCK  = 2'd2
  } arbState_t;

  // Explicit mod-5 increment; a plain 3-bit add would walk through 5..7.
  function automatic logic [PTR_W-1:0] inc_mod5(input logic [PTR_W-1:0] p);
    return (p >= 3'd4) ? 3'd0 : p + 3'd1;
  endfunction

  // Port (ptr+k) mod 5 for k = 0..4.
  function automatic logic [PTR_W-1:0] port_of(input logic [PTR_W-1:0] p,
                                               input int k);
    logic [3:0] s;
    s = {1'b0, p} + 4'(k);
    if (s >= 4'd5) s = s - 4'd5;
    return s[PTR_W-1:0];
  endfunction

  // rot[4-k] = req[(ptr+k) mod 5]: the priority port lands on the top bit.
  function automatic logic [NUM_PORT-1:0] rotate5(input logic [NUM_PORT-1:0] req,
                                                  input logic [PTR_W-1:0] p);
    logic [NUM_PORT-1:0] rot;
    rot = '0;
    for (int k = 0; k < NUM_PORT; k++)
      rot[3'(4 - k)] = req[port_of(p, k)];
    return rot;
  endfunction

  // Inverse of rotate5: rot bit 4-k goes back to port (ptr+k) mod 5.
  function automatic logic [NUM_PORT-1:0] unrotate5(input logic [NUM_PORT-1:0] rot,
                                                    input logic [PTR_W-1:0] p);
    logic [NUM_PORT-1:0] vec;
    vec = '0;
    for (int k = 0; k < NUM_PORT; k++)
      vec[port_of(p, k)] = rot[3'(4 - k)];
    return vec;
  endfunction

endpackage

// File: rtl/rr_port_arbiter_prio_pick5.sv
// prio_pick5
//   Combinational fixed-priority picker: one-hot of the highest set bit of a
//   5-bit vector; all-zeros in gives all-zeros out.
//   Ports:
//     in    [4:0]  candidate vector
//     pick  [4:0]  one-hot of the highest set bit of in
module prio_pick5 (
  input  logic [4:0] in,
  output logic [4:0] pick
);

  always_comb begin
    pick = 5'b00000;
    if      (in[4]) pick = 5'b10000;
    else if (in[3]) pick = 5'b01000;
    else if (in[2]) pick = 5'b00100;
    else if (in[1]) pick = 5'b00010;
    else if (in[0]) pick = 5'b00001;
  end

endmodule

// File: rtl/rr_port_arbiter.sv
// rr_port_arbiter
//   Rotating-priority output-port arbiter. Requests are rotated so the current
//   priority port sits at the top bit, a fixed highest-bit picker selects one,
//   and the result is un-rotated into a registered one-hot grant with a
//   valid/ready handshake. A grant can be held across flits with lock; the
//   priority pointer advances past the granted port on each release.
//   Ports:
//     clk          router clock
//     rst_n        asynchronous active-low reset
//     req          per-port requests, sampled only in IDLE
//     req_valid    qualifies req
//     lock         keep the grant after this handshake
//     grant_ready  downstream accepts the grant this cycle
//     grant_valid  registered grant valid
//     grant        registered one-hot granted port
//     grant_idx    registered binary index of the granted port
//     ptr          current priority pointer (0..4)
module rr_port_arbiter #(
  parameter int NUM_PORT = rr_port_arbiter_pkg::NUM_PORT,
  parameter int PTR_W    = rr_port_arbiter_pkg::PTR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_PORT-1:0] req,
  input  logic                req_valid,
  input  logic                lock,
  input  logic                grant_ready,
  output logic                grant_valid,
  output logic [NUM_PORT-1:0] grant,
  output logic [PTR_W-1:0]    grant_idx,
  output logic [PTR_W-1:0]    ptr
);

  import rr_port_arbiter_pkg::*;

  arbState_t           state;
  logic [NUM_PORT-1:0] rotReq;
  logic [NUM_PORT-1:0] rotPick;
  logic [NUM_PORT-1:0] pickGrant;
  logic [PTR_W-1:0]    pickIdx;
  logic                handshake;

  assign rotReq    = rotate5(req, ptr);
  assign pickGrant = unrotate5(rotPick, ptr);
  assign handshake = grant_valid && grant_ready;

  prio_pick5 uPick (
    .in   (rotReq),
    .pick (rotPick)
  );

  // One-hot to binary; pickGrant has at most one bit set.
  always_comb begin
    pickIdx = '0;
    for (int i = 0; i < NUM_PORT; i++)
      if (pickGrant[i]) pickIdx = pickIdx | PTR_W'(i);
  end

  // Output/pointer register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      grant_valid <= 1'b0;
      grant       <= '0;
      grant_idx   <= '0;
      ptr         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && (req != '0)) begin
            grant       <= pickGrant;
            grant_idx   <= pickIdx;
            grant_valid <= 1'b1;
            state       <= ST_GRANT;
          end
        end
        ST_GRANT, ST_LOCK: begin
          if (handshake) begin
            if (lock) begin
              state <= ST_LOCK;
            end else begin
              // Release: next search starts just past the port we served.
              ptr         <= inc_mod5(grant_idx);
              grant_valid <= 1'b0;
              grant       <= '0;
              state       <= ST_IDLE;
            end
          end
        end
        default: begin
          state       <= ST_IDLE;
          grant_valid <= 1'b0;
          grant       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_port_arbiter.sv
module tb_rr_port_arbiter;

  logic       clk;
  logic       rst_n;
  logic [4:0] req;
  logic       req_valid;
  logic       lock;
  logic       grant_ready;
  logic       grant_valid;
  logic [4:0] grant;
  logic [2:0] grant_idx;
  logic [2:0] ptr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0] rq;
    logic       rv;
    logic       lk;
    logic       rdy;
    logic       ev;
    logic [4:0] eg;
    logic [2:0] ei;
    logic [2:0] ep;
  } vec_t;

  vec_t sbq[$];
  vec_t tbl[18];

  rr_port_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_valid   (req_valid),
    .lock        (lock),
    .grant_ready (grant_ready),
    .grant_valid (grant_valid),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .ptr         (ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic step(input vec_t v, input string tag);
    vec_t e;
    req         = v.rq;
    req_valid   = v.rv;
    lock        = v.lk;
    grant_ready = v.rdy;
    sbq.push_back(v);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk({tag, ".valid"}, 32'(grant_valid), 32'(e.ev));
    chk({tag, ".grant"}, 32'(grant), 32'(e.eg));
    if (e.ev) chk({tag, ".idx"}, 32'(grant_idx), 32'(e.ei));
    chk({tag, ".ptr"}, 32'(ptr), 32'(e.ep));
  endtask

  function automatic vec_t mk(input logic [4:0] rq, input logic rv, input logic lk,
                              input logic rdy, input logic ev, input logic [4:0] eg,
                              input logic [2:0] ei, input logic [2:0] ep);
    vec_t v;
    v.rq = rq; v.rv = rv; v.lk = lk; v.rdy = rdy;
    v.ev = ev; v.eg = eg; v.ei = ei; v.ep = ep;
    return v;
  endfunction

  initial begin
    vec_t v;
    logic [2:0] mp;
    logic [4:0] hg;

    //            req       rv    lk    rdy   ev    grant     idx   ptr
    tbl[0]  = mk(5'b00000, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000, 3'd0, 3'd0); // empty req
    tbl[1]  = mk(5'b11111, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 3'd0, 3'd0); // not valid
    tbl[2]  = mk(5'b10110, 1'b1, 1'b0, 1'b0, 1'b1, 5'b00010, 3'd1, 3'd0); // rotation
    tbl[3]  = mk(5'b11111, 1'b1, 1'b1, 1'b0, 1'b1, 5'b00010, 3'd1, 3'd0); // stalled
    tbl[4]  = mk(5'b00000, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 3'd0, 3'd2); // release
    tbl[5]  = mk(5'b00011, 1'b1, 1'b0, 1'b0, 1'b1, 5'b00001, 3'd0, 3'd2); // ptr=2 wraps to 0
    tbl[6]  = mk(5'b00000, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 3'd0, 3'd1);
    tbl[7]  = mk(5'b00010, 1'b1, 1'b0, 1'b0, 1'b1, 5'b00010, 3'd1, 3'd1);
    tbl[8]  = mk(5'b00000, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 3'd0, 3'd2);
    tbl[9]  = mk(5'b00100, 1'b1, 1'b0, 1'b0, 1'b1, 5'b00100, 3'd2, 3'd2); // lock test grant
    tbl[10] = mk(5'b11011, 1'b1, 1'b1, 1'b1, 1'b1, 5'b00100, 3'd2, 3'd2); // locked flit 1
    tbl[11] = mk(5'b00000, 1'b0, 1'b1, 1'b1, 1'b1, 5'b00100, 3'd2, 3'd2); // locked flit 2
    tbl[12] = mk(5'b01000, 1'b1, 1'b1, 1'b1, 1'b1, 5'b00100, 3'd2, 3'd2); // locked flit 3
    tbl[13] = mk(5'b11111, 1'b1, 1'b0, 1'b1, 1'b0, 5'b00000, 3'd0, 3'd3); // release flit
    tbl[14] = mk(5'b00001, 1'b1, 1'b0, 1'b0, 1'b1, 5'b00001, 3'd0, 3'd3); // only port 0 asks
    tbl[15] = mk(5'b00000, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 3'd0, 3'd1);
    tbl[16] = mk(5'b10000, 1'b1, 1'b0, 1'b0, 1'b1, 5'b10000, 3'd4, 3'd1); // port 4
    tbl[17] = mk(5'b00000, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 3'd0, 3'd0); // 4 -> 0

    rst_n = 1'b0; req = '0; req_valid = 1'b0; lock = 1'b0; grant_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", 32'(grant_valid), 32'd0);
    chk("rst.grant", 32'(grant), 32'd0);
    chk("rst.idx",   32'(grant_idx), 32'd0);
    chk("rst.ptr",   32'(ptr), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) step(tbl[i], $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of a grant.
    step(mk(5'b01000, 1'b1, 1'b0, 1'b0, 1'b1, 5'b01000, 3'd3, 3'd0), "preRst");
    #2 rst_n = 1'b0;
    #1;
    chk("arst.valid", 32'(grant_valid), 32'd0);
    chk("arst.grant", 32'(grant), 32'd0);
    chk("arst.idx",   32'(grant_idx), 32'd0);
    chk("arst.ptr",   32'(ptr), 32'd0);
    req_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Fairness: all ports requesting, every grant followed by an IDLE cycle.
    mp = 3'd0;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) begin
        hg = 5'b00001 << mp;
        step(mk(5'b11111, 1'b1, 1'b0, 1'b1, 1'b1, hg, mp, mp), $sformatf("fair%0d", i));
      end else begin
        mp = (mp == 3'd4) ? 3'd0 : mp + 3'd1;
        step(mk(5'b11111, 1'b1, 1'b0, 1'b1, 1'b0, 5'b00000, 3'd0, mp), $sformatf("fair%0d", i));
      end
    end
    chk("fair.wrap", 32'(ptr), 32'd0);

    // Back-pressure with random req/lock: everything holds.
    step(mk(5'b11111, 1'b1, 1'b0, 1'b0, 1'b1, 5'b00001, 3'd0, 3'd0), "bpGrant");
    for (int i = 0; i < 5; i++) begin
      v = mk(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'b0, 1'b1, 5'b00001, 3'd0, 3'd0);
      step(v, $sformatf("bp%0d", i));
    end
    step(mk(5'b00110, 1'b1, 1'b0, 1'b1, 1'b0, 5'b00000, 3'd0, 3'd1), "bpRelease");
    step(mk(5'b00000, 1'b1, 1'b0, 1'b1, 1'b0, 5'b00000, 3'd0, 3'd1), "bpEmpty");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
